// File: rtl/regfile_pkg.sv
// Shared defaults for the register-file family: geometry and the reset contents.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int MAX_DATA_WIDTH     = 64;

  localparam logic [MAX_DATA_WIDTH-1:0] RESET_VALUE = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, write bypass, zero-register override,
// and enable-held data/busy output registers.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         re_i,
  input  logic [ADDR_WIDTH-1:0]                        addr_i,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   regs_i,
  input  logic [(2**ADDR_WIDTH)-1:0]                   busy_next_i,
  input  logic                                         we_i,
  input  logic [ADDR_WIDTH-1:0]                        write_addr_i,
  input  logic [DATA_WIDTH-1:0]                        write_data_i,
  output logic [DATA_WIDTH-1:0]                        data_o,
  output logic                                         busy_o
);

  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  busy_d, busy_q;

  // Busy arrives already resolved (write-clear then lock-set); data needs the bypass here.
  always_comb begin
    data_d = regs_i[addr_i];
    busy_d = busy_next_i[addr_i];
    if (we_i && (write_addr_i == addr_i)) begin
      data_d = write_data_i;
    end
    if (ZERO_REG && (addr_i == '0)) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VALUE[DATA_WIDTH-1:0];
      busy_q <= 1'b0;
    end else if (re_i) begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// Two-read/one-write register file with a per-register busy scoreboard for
// read-after-write hazard detection between decode (lock) and writeback (write).
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       lock,
  input  logic [ADDR_WIDTH-1:0]      lock_addr,
  input  logic                       re1,
  input  logic                       re2,
  input  logic [ADDR_WIDTH-1:0]      read_addr1,
  input  logic [ADDR_WIDTH-1:0]      read_addr2,
  output logic [DATA_WIDTH-1:0]      read_data1,
  output logic [DATA_WIDTH-1:0]      read_data2,
  output logic                       read_busy1,
  output logic                       read_busy2,
  output logic [(2**ADDR_WIDTH)-1:0] busy_vec
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit IS_ZERO = ZERO_REG && (gi == 0);
      logic wr_hit;
      logic lk_hit;
      assign wr_hit = we   && (write_addr == ADDR_WIDTH'(gi)) && !IS_ZERO;
      assign lk_hit = lock && (lock_addr  == ADDR_WIDTH'(gi)) && !IS_ZERO;
      assign regs_d[gi] = wr_hit ? write_data : regs_q[gi];
      // A lock in the same cycle as the completing write wins: a newer producer is pending.
      assign busy_d[gi] = lk_hit | (busy_q[gi] & ~wr_hit);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= {DEPTH{RESET_VALUE[DATA_WIDTH-1:0]}};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port1 (
    .clk         (clk),
    .rst         (rst),
    .re_i        (re1),
    .addr_i      (read_addr1),
    .regs_i      (regs_q),
    .busy_next_i (busy_d),
    .we_i        (we),
    .write_addr_i(write_addr),
    .write_data_i(write_data),
    .data_o      (read_data1),
    .busy_o      (read_busy1)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_port2 (
    .clk         (clk),
    .rst         (rst),
    .re_i        (re2),
    .addr_i      (read_addr2),
    .regs_i      (regs_q),
    .busy_next_i (busy_d),
    .we_i        (we),
    .write_addr_i(write_addr),
    .write_data_i(write_data),
    .data_o      (read_data2),
    .busy_o      (read_busy2)
  );

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench: vector table on the 8-bit zero-register instance plus
// hand sequences for reset, ZERO_REG=0 reads and the 16-bit configuration.
module tb_scoreboard_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       we, lock, re1, re2;
  logic [2:0] write_addr, lock_addr, read_addr1, read_addr2;
  logic [7:0] write_data;

  logic [7:0] z_rd1, z_rd2, n_rd1, n_rd2;
  logic       z_rb1, z_rb2, n_rb1, n_rb2;
  logic [7:0] z_bv, n_bv;

  logic        w_we, w_lock, w_re1, w_re2;
  logic [3:0]  w_wa, w_la, w_ra1, w_ra2;
  logic [15:0] w_wd, w_rd1, w_rd2, w_bv;
  logic        w_rb1, w_rb2;

  scoreboard_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .lock(lock), .lock_addr(lock_addr), .re1(re1), .re2(re2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(z_rd1), .read_data2(z_rd2), .read_busy1(z_rb1), .read_busy2(z_rb2),
    .busy_vec(z_bv));

  scoreboard_register_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .lock(lock), .lock_addr(lock_addr), .re1(re1), .re2(re2),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(n_rd1), .read_data2(n_rd2), .read_busy1(n_rb1), .read_busy2(n_rb2),
    .busy_vec(n_bv));

  scoreboard_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1'b1)) dut_w (
    .clk(clk), .rst(rst), .we(w_we), .write_addr(w_wa), .write_data(w_wd),
    .lock(w_lock), .lock_addr(w_la), .re1(w_re1), .re2(w_re2),
    .read_addr1(w_ra1), .read_addr2(w_ra2),
    .read_data1(w_rd1), .read_data2(w_rd2), .read_busy1(w_rb1), .read_busy2(w_rb2),
    .busy_vec(w_bv));

  typedef struct {
    logic       we;   logic [2:0] wa;  logic [7:0] wd;
    logic       lk;   logic [2:0] la;
    logic       re1;  logic [2:0] ra1; logic re2; logic [2:0] ra2;
    logic [7:0] rd1;  logic       rb1; logic [7:0] rd2; logic rb2; logic [7:0] bv;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; lock = 0; re1 = 0; re2 = 0;
    write_addr = 0; write_data = 0; lock_addr = 0; read_addr1 = 0; read_addr2 = 0;
  endtask

  function automatic vec_t mk(logic w, logic [2:0] wa, logic [7:0] wd, logic l, logic [2:0] la,
                              logic r1, logic [2:0] a1, logic r2, logic [2:0] a2,
                              logic [7:0] d1, logic b1, logic [7:0] d2, logic b2, logic [7:0] bv);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.lk = l; v.la = la;
    v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
    v.rd1 = d1; v.rb1 = b1; v.rd2 = d2; v.rb2 = b2; v.bv = bv;
    return v;
  endfunction

  initial begin
    //               we wa  wd     lk la  re1 a1 re2 a2  rd1    b1 rd2    b2 bv
    vecs.push_back(mk(1, 1, 8'h55, 0, 0, 1, 1, 0, 0, 8'h55, 0, 8'h00, 0, 8'h00)); // bypass
    vecs.push_back(mk(1, 5, 8'h3C, 0, 0, 1, 5, 1, 1, 8'h3C, 0, 8'h55, 0, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 8'h55, 0, 8'h00)); // hold
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 2, 0, 0, 8'h00, 1, 8'h55, 0, 8'h04)); // lock k
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h00, 1, 8'h00, 1, 8'h04));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 8'h04));
    vecs.push_back(mk(1, 2, 8'h11, 0, 0, 1, 2, 0, 0, 8'h11, 0, 8'h00, 1, 8'h00)); // k+3
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 0, 0, 1, 3, 8'h11, 0, 8'h00, 1, 8'h08));
    vecs.push_back(mk(1, 3, 8'h7E, 1, 3, 1, 3, 1, 3, 8'h7E, 1, 8'h7E, 1, 8'h08)); // collide
    vecs.push_back(mk(1, 0, 8'hFF, 1, 0, 1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h08)); // zero reg
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 3, 8'h00, 0, 8'h7E, 1, 8'h08));
    vecs.push_back(mk(1, 3, 8'h01, 0, 0, 1, 3, 0, 0, 8'h01, 0, 8'h7E, 1, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1, 7, 0, 0, 1, 7, 8'h01, 0, 8'h00, 1, 8'h80));

    idle();
    w_we = 0; w_lock = 0; w_re1 = 0; w_re2 = 0;
    w_wa = 0; w_la = 0; w_ra1 = 0; w_ra2 = 0; w_wd = 0;
    rst = 1;
    #1;
    we = 1; write_addr = 1; write_data = 8'h99; lock = 1; lock_addr = 4; re1 = 1; read_addr1 = 1;
    step();
    step();
    chk("reset_rd1", {24'h0, z_rd1}, 32'h0);
    chk("reset_busy", {30'h0, z_rb1, z_rb2}, 32'h0);
    chk("reset_bv", {24'h0, z_bv}, 32'h0);
    chk("reset_w_bv", {16'h0, w_bv}, 32'h0);
    idle();
    rst = 0;

    foreach (vecs[i]) begin
      we = vecs[i].we; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      lock = vecs[i].lk; lock_addr = vecs[i].la;
      re1 = vecs[i].re1; read_addr1 = vecs[i].ra1;
      re2 = vecs[i].re2; read_addr2 = vecs[i].ra2;
      step();
      $display("vec %0d: rd1=%h/%b rd2=%h/%b busy_vec=%h", i, z_rd1, z_rb1, z_rd2, z_rb2, z_bv);
      chk($sformatf("vec%0d_rd1", i), {24'h0, z_rd1}, {24'h0, vecs[i].rd1});
      chk($sformatf("vec%0d_rb1", i), {31'h0, z_rb1}, {31'h0, vecs[i].rb1});
      chk($sformatf("vec%0d_rd2", i), {24'h0, z_rd2}, {24'h0, vecs[i].rd2});
      chk($sformatf("vec%0d_rb2", i), {31'h0, z_rb2}, {31'h0, vecs[i].rb2});
      chk($sformatf("vec%0d_bv", i), {24'h0, z_bv}, {24'h0, vecs[i].bv});
    end

    // reg0 on the non-zero instance took 0xFF and the lock in vec 9
    idle();
    re1 = 1; read_addr1 = 0;
    step();
    $display("zero-reg off: rd1=%h/%b busy_vec=%h", n_rd1, n_rb1, n_bv);
    chk("nzero_rd0", {24'h0, n_rd1}, 32'h0000_00FF);
    chk("nzero_rb0", {31'h0, n_rb1}, 32'h1);

    // reset pulsed between edges right after a write of reg1
    idle();
    we = 1; write_addr = 1; write_data = 8'h55;
    step();
    idle();
    #2 rst = 1;
    #1;
    $display("reset pulse: rd1=%h rd2=%h busy_vec=%h", z_rd1, z_rd2, z_bv);
    chk("rstpulse_rd", {16'h0, z_rd1, z_rd2}, 32'h0);
    chk("rstpulse_rb", {30'h0, z_rb1, z_rb2}, 32'h0);
    chk("rstpulse_bv", {16'h0, z_bv, n_bv}, 32'h0);
    rst = 0;
    re1 = 1; read_addr1 = 1;
    step();
    chk("rstpulse_reg1", {24'h0, z_rd1}, 32'h0);

    // write and lock on an edge that sees rst high are discarded
    rst = 1; we = 1; write_addr = 1; write_data = 8'h55; lock = 1; lock_addr = 4; re1 = 0;
    step();
    rst = 0;
    idle();
    re1 = 1; read_addr1 = 1; re2 = 1; read_addr2 = 4;
    step();
    $display("reset edge: rd1=%h rd2=%h/%b busy_vec=%h", z_rd1, z_rd2, z_rb2, z_bv);
    chk("rstedge_reg1", {24'h0, z_rd1}, 32'h0);
    chk("rstedge_busy4", {31'h0, z_rb2}, 32'h0);
    chk("rstedge_bv", {24'h0, z_bv}, 32'h0);

    // basic write/read; reg0 is a real register only with ZERO_REG=0
    idle();
    we = 1; write_addr = 0; write_data = 8'hAA;
    step();
    write_addr = 1; write_data = 8'h55;
    step();
    idle();
    re1 = 1; read_addr1 = 0; re2 = 1; read_addr2 = 1;
    step();
    $display("basic: n rd1=%h rd2=%h, z rd1=%h rd2=%h", n_rd1, n_rd2, z_rd1, z_rd2);
    chk("basic_n_rd1", {24'h0, n_rd1}, 32'h0000_00AA);
    chk("basic_n_rd2", {24'h0, n_rd2}, 32'h0000_0055);
    chk("basic_z_rd1", {24'h0, z_rd1}, 32'h0);
    chk("basic_z_rd2", {24'h0, z_rd2}, 32'h0000_0055);
    idle();

    // 16-bit, 16-entry configuration
    w_we = 1; w_wa = 15; w_wd = 16'hBEEF; w_re1 = 1; w_ra1 = 15;
    step();
    chk("w_rd15", {16'h0, w_rd1}, 32'h0000_BEEF);
    w_we = 1; w_wa = 0; w_wd = 16'hFFFF; w_lock = 1; w_la = 0;
    w_re1 = 1; w_ra1 = 0; w_re2 = 1; w_ra2 = 15;
    step();
    $display("w zero: rd1=%h/%b rd2=%h busy_vec=%h", w_rd1, w_rb1, w_rd2, w_bv);
    chk("w_rd0", {16'h0, w_rd1}, 32'h0);
    chk("w_rb0", {31'h0, w_rb1}, 32'h0);
    chk("w_rd15b", {16'h0, w_rd2}, 32'h0000_BEEF);
    chk("w_bv0", {16'h0, w_bv}, 32'h0);
    w_we = 0; w_lock = 1; w_la = 15; w_re1 = 0; w_re2 = 1; w_ra2 = 15;
    step();
    $display("w lock15: rd2=%h/%b busy_vec=%h", w_rd2, w_rb2, w_bv);
    chk("w_rb15", {31'h0, w_rb2}, 32'h1);
    chk("w_bv15", {16'h0, w_bv}, 32'h0000_8000);
    w_lock = 0; w_re2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised successor to the 8-bit, 8-entry, two-read/one-write register file. It adds:
- registered read ports with enables and write-to-read bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard, so a pipelined datapath can mark a destination as pending and detect read-after-write hazards.

It sits between decode (lock/read) and writeback (write) in the team's small pipelined datapath.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH (localparam, not overridable)
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and never becomes busy

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- we  in  1  write enable
- write_addr  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- lock  in  1  mark lock_addr busy (pending producer issued)
- lock_addr  in  ADDR_WIDTH  register to mark busy
- re1, re2  in  1  read enables, ports 1/2
- read_addr1, read_addr2  in  ADDR_WIDTH  read addresses
- read_data1, read_data2  out  DATA_WIDTH  registered read data
- read_busy1, read_busy2  out  1  registered busy flag of the register read
- busy_vec  out  DEPTH  registered busy bit of every register

## Operation
- Storage: DEPTH x DATA_WIDTH registers plus a DEPTH-bit busy vector.
- Write: on a rising edge with we=1, reg[write_addr] <= write_data and busy[write_addr] <= 0.
- Lock: on a rising edge with lock=1, busy[lock_addr] <= 1.
- Same address, same cycle (we=1, lock=1, write_addr==lock_addr): the data is written and busy ends at 1. Lock wins, because a new producer supersedes the completed one.
- Read port n, on an edge with ren=1:
  - read_datan <= next-state contents of reg[read_addrn]. If we=1 and write_addr==read_addrn, this is write_data (bypass).
  - read_busyn <= next-state busy bit of that register, after the write-clear and lock-set of the same cycle.
- Read port n with ren=0: read_datan and read_busyn hold their values.
- Both ports may read the same address; both return identical results.
- ZERO_REG=1, address 0: writes are dropped and locks are dropped. Reads return 0 and busy 0 regardless of bypass.
- No arbitration or stalling. The block never back-pressures; the consumer acts on read_busyn.

## Timing
- Reset (rst=1, async): all registers 0, busy_vec 0, read_data1/2 0, read_busy1/2 0, effective immediately and held while rst=1.
- Reset asserted mid-operation discards any same-edge write or lock. The first edge after deassertion is a normal operating edge.
- Read latency: 1 cycle. Address and re presented before edge k; data valid after edge k.
- Write visibility: 0 extra cycles via bypass. A read and a write to the same address at edge k return the new value after edge k.
- busy_vec reflects state after each edge.
- Busy lifecycle: lock at edge k gives busy=1 after edge k. A matching write at edge m>k gives busy=0 after edge m.
- Wrap-around is not applicable. All addresses 0..DEPTH-1 are valid with no out-of-range case.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants, also used by the 8-bit register file;
  - the reset value constant (all zeros).
- Sub-module regfile_read_port, instantiated twice, contains:
  - address mux over storage;
  - bypass compare against write_addr/we;
  - zero-register override;
  - the enable-held output registers for data and busy.
- Top level owns storage, busy vector and write/lock update logic, and passes next-state data/busy to both ports.

## Test plan
Run with DATA_WIDTH=8, ADDR_WIDTH=3, ZERO_REG=1 unless noted.
- **Reset mid-write:** write reg1=0x55, then pulse rst between edges. Required: all outputs go 0 immediately, and a read of reg1 returns 0x00.
- **Basic write/read:** write reg0=0xAA (ZERO_REG=0), reg1=0x55 on consecutive edges, then re1/re2 with addresses 0/1. Required: read_data1=0xAA, read_data2=0x55 one cycle later.
- **Bypass:** we=1, write_addr=5, write_data=0x3C with re1=1, read_addr1=5 on the same edge. Required: read_data1=0x3C after that edge; re1=0 next cycle holds 0x3C.
- **Scoreboard:**
  - lock reg2 at edge k. Required: busy_vec=8'h04; a read of reg2 gives read_busy=1.
  - write reg2=0x11 at edge k+3. Required: busy_vec=0; read_busy=0, data 0x11.
- **Lock/write collision:** busy reg3, then lock=1 and we=1 on reg3 with data 0x7E on the same edge. Required: reg3 reads 0x7E with busy still 1.
- **Zero register:** write reg0=0xFF and lock reg0. Required: reads return 0x00, busy 0, busy_vec bit0=0. Repeat at DATA_WIDTH=16, ADDR_WIDTH=4 on reg15=0xBEEF.
